// File: rtl/i2c_slave_regs_pkg.sv
// Shared definitions for the I2C target: FSM state encodings, R/W bit position,
// ACK/NACK line levels and the address-match helper.
package i2c_slave_regs_pkg;

    typedef enum logic [3:0] {
        I2C_S_IDLE      = 4'd0,
        I2C_S_ADDR      = 4'd1,
        I2C_S_ADDR_ACK  = 4'd2,
        I2C_S_WR_DATA   = 4'd3,
        I2C_S_WR_ACK    = 4'd4,
        I2C_S_RD_LOAD   = 4'd5,
        I2C_S_RD_DATA   = 4'd6,
        I2C_S_RD_ACK    = 4'd7,
        I2C_S_WAIT_STOP = 4'd8
    } i2c_state_e;

    localparam int unsigned I2C_RW_BIT    = 0;
    localparam int unsigned I2C_BYTE_BITS = 8;
    localparam logic        I2C_ACK       = 1'b0;
    localparam logic        I2C_NACK      = 1'b1;

    // Header byte carries the 7-bit address above the R/W bit.
    function automatic logic addr_match(input logic [7:0] hdr, input logic [6:0] dev);
        return (hdr[7:1] == dev);
    endfunction

endpackage

// File: rtl/i2c_slave_sync.sv
// Two-flop synchroniser plus history flop for SCL/SDA, producing SCL edge
// pulses and START/STOP detection on the synchronised levels.
module i2c_slave_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    // [0] metastability flop, [1] synchronised level, [2] previous level.
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    // Shift both lines through the synchroniser; an idle bus is high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl_i};
            sda_q <= {sda_q[1:0], sda_i};
        end
    end

    assign sda_o      = sda_q[1];
    assign scl_rise_o = scl_q[1] & ~scl_q[2];
    assign scl_fall_o = ~scl_q[1] & scl_q[2];
    assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with 7-bit address match and an auto-incrementing register
// pointer onto a simple synchronous local register bus.
module i2c_slave_regs
    import i2c_slave_regs_pkg::*;
#(
    parameter logic [6:0]  SLV_ADDR = 7'h50,
    parameter int unsigned AWIDTH   = 3,
    parameter int unsigned DWIDTH   = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Scl_i,
    input  logic              Sda_i,
    output logic              Sda_oe,
    output logic [AWIDTH-1:0] Reg_addr,
    output logic [DWIDTH-1:0] Reg_wdata,
    output logic              Reg_wr,
    input  logic [DWIDTH-1:0] Reg_rdata,
    output logic              Busy,
    output logic              Sel,
    output logic              Rd_strobe
);

    logic sda_s;
    logic scl_rise_s;
    logic scl_fall_s;
    logic start_s;
    logic stop_s;

    i2c_slave_sync u_sync (
        .clk_i      (Clk),
        .rst_i      (Rst),
        .scl_i      (Scl_i),
        .sda_i      (Sda_i),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise_s),
        .scl_fall_o (scl_fall_s),
        .start_o    (start_s),
        .stop_o     (stop_s)
    );

    i2c_state_e        state_q,     state_d;
    logic [3:0]        bit_cnt_q,   bit_cnt_d;
    logic [DWIDTH-1:0] shift_q,     shift_d;
    logic [DWIDTH-1:0] tx_q,        tx_d;
    logic              rw_q,        rw_d;
    logic              first_q,     first_d;
    logic              sda_oe_q,    sda_oe_d;
    logic              sel_q,       sel_d;
    logic              busy_q,      busy_d;
    logic [AWIDTH-1:0] reg_addr_q,  reg_addr_d;
    logic [DWIDTH-1:0] reg_wdata_q, reg_wdata_d;
    logic              reg_wr_q,    reg_wr_d;
    logic              rd_strobe_q, rd_strobe_d;

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= I2C_S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= '0;
            tx_q        <= '0;
            rw_q        <= 1'b0;
            first_q     <= 1'b0;
            sda_oe_q    <= 1'b0;
            sel_q       <= 1'b0;
            busy_q      <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_wr_q    <= 1'b0;
            rd_strobe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            first_q     <= first_d;
            sda_oe_q    <= sda_oe_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_wr_q    <= reg_wr_d;
            rd_strobe_q <= rd_strobe_d;
        end
    end

    // Next-state and output decode; SDA only moves in the cycle after an SCL fall.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        first_d     = first_q;
        sda_oe_d    = sda_oe_q;
        sel_d       = sel_q;
        busy_d      = busy_q;
        reg_wdata_d = reg_wdata_q;
        reg_wr_d    = 1'b0;
        rd_strobe_d = 1'b0;

        // The pointer advances one cycle after each write strobe or read load.
        if (reg_wr_q || rd_strobe_q) begin
            reg_addr_d = reg_addr_q + AWIDTH'(1);
        end else begin
            reg_addr_d = reg_addr_q;
        end

        if (stop_s) begin
            state_d  = I2C_S_IDLE;
            sda_oe_d = 1'b0;
            sel_d    = 1'b0;
            busy_d   = 1'b0;
        end else if (start_s) begin
            state_d   = I2C_S_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            sel_d     = 1'b0;
            busy_d    = 1'b1;
        end else begin
            case (state_q)
                I2C_S_IDLE: begin
                    sda_oe_d = 1'b0;
                end

                I2C_S_ADDR: begin
                    if (scl_rise_s) begin
                        shift_d   = {shift_q[DWIDTH-2:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_s && (bit_cnt_q == 4'(I2C_BYTE_BITS))) begin
                        bit_cnt_d = 4'd0;
                        if (addr_match(shift_q, SLV_ADDR)) begin
                            sda_oe_d = ~I2C_ACK;
                            sel_d    = 1'b1;
                            rw_d     = shift_q[I2C_RW_BIT];
                            state_d  = I2C_S_ADDR_ACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = I2C_S_WAIT_STOP;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end

                I2C_S_ADDR_ACK: begin
                    if (scl_fall_s) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q == 1'b0) begin
                            sda_oe_d = 1'b0;
                            first_d  = 1'b1;
                            state_d  = I2C_S_WR_DATA;
                        end else begin
                            state_d  = I2C_S_RD_LOAD;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end

                I2C_S_WR_DATA: begin
                    if (scl_rise_s) begin
                        shift_d   = {shift_q[DWIDTH-2:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_s && (bit_cnt_q == 4'(I2C_BYTE_BITS))) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = ~I2C_ACK;
                        state_d   = I2C_S_WR_ACK;
                        // First data byte after the header is the register pointer.
                        if (first_q) begin
                            reg_addr_d = shift_q[AWIDTH-1:0];
                            first_d    = 1'b0;
                        end else begin
                            reg_wdata_d = shift_q;
                            reg_wr_d    = 1'b1;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end

                I2C_S_WR_ACK: begin
                    if (scl_fall_s) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = I2C_S_WR_DATA;
                    end else begin
                        state_d = state_q;
                    end
                end

                I2C_S_RD_LOAD: begin
                    tx_d        = Reg_rdata;
                    rd_strobe_d = 1'b1;
                    sda_oe_d    = ~Reg_rdata[DWIDTH-1];
                    bit_cnt_d   = 4'd0;
                    state_d     = I2C_S_RD_DATA;
                end

                I2C_S_RD_DATA: begin
                    if (scl_fall_s) begin
                        if (bit_cnt_q == 4'(I2C_BYTE_BITS - 1)) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = I2C_S_RD_ACK;
                        end else begin
                            // Rotate so the next bit to send sits just below the MSB.
                            tx_d      = {tx_q[DWIDTH-2:0], tx_q[DWIDTH-1]};
                            sda_oe_d  = ~tx_q[DWIDTH-2];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end

                I2C_S_RD_ACK: begin
                    if (scl_rise_s) begin
                        if (sda_s == I2C_NACK) begin
                            sel_d   = 1'b0;
                            state_d = I2C_S_WAIT_STOP;
                        end else begin
                            bit_cnt_d = 4'd1;
                        end
                    end else if (scl_fall_s && (bit_cnt_q == 4'd1)) begin
                        bit_cnt_d = 4'd0;
                        state_d   = I2C_S_RD_LOAD;
                    end else begin
                        state_d = state_q;
                    end
                end

                I2C_S_WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    state_d  = I2C_S_IDLE;
                    sda_oe_d = 1'b0;
                    sel_d    = 1'b0;
                end
            endcase
        end
    end

    assign Sda_oe    = sda_oe_q;
    assign Reg_addr  = reg_addr_q;
    assign Reg_wdata = reg_wdata_q;
    assign Reg_wr    = reg_wr_q;
    assign Busy      = busy_q;
    assign Sel       = sel_q;
    assign Rd_strobe = rd_strobe_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Scoreboard bench for i2c_slave_regs: a bus-level I2C master drives random
// transactions; a register-map model predicts local-bus events and read data.
module tb_i2c_slave_regs;
    import i2c_slave_regs_pkg::*;

    localparam int Q = 4;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Scl_i, Sda_i, Sda_oe, Reg_wr, Busy, Sel, Rd_strobe;
    logic [2:0] Reg_addr;
    logic [7:0] Reg_wdata, Reg_rdata;
    logic       m_scl, m_sda;

    int n_cmp = 0;
    int n_err = 0;
    int sda_viol = 0;

    typedef struct packed { logic [2:0] a; logic [7:0] d; } wr_exp_t;
    wr_exp_t    exp_wr_q[$];
    logic [2:0] exp_rd_q[$];
    logic [7:0] wr_bytes[$];
    logic [7:0] periph_mem [8];
    logic [7:0] model_mem [8];
    int         model_ptr;

    always #5 Clk = ~Clk;

    assign Scl_i     = m_scl;
    assign Sda_i     = m_sda & ~Sda_oe;
    assign Reg_rdata = periph_mem[Reg_addr];

    i2c_slave_regs #(.SLV_ADDR(7'h50), .AWIDTH(3)) dut (
        .Clk(Clk), .Rst(Rst), .Scl_i(Scl_i), .Sda_i(Sda_i), .Sda_oe(Sda_oe),
        .Reg_addr(Reg_addr), .Reg_wdata(Reg_wdata), .Reg_wr(Reg_wr),
        .Reg_rdata(Reg_rdata), .Busy(Busy), .Sel(Sel), .Rd_strobe(Rd_strobe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Peripheral register file served by the DUT's local bus.
    always @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < 8; i++) periph_mem[i] <= 8'h10 + 8'(i);
        end else if (Reg_wr) begin
            periph_mem[Reg_addr] <= Reg_wdata;
        end
    end

    // Monitor: every local-bus strobe must match the oldest expectation.
    always @(negedge Clk) begin
        wr_exp_t    e;
        logic [2:0] ra;
        if (!Rst && Reg_wr) begin
            if (exp_wr_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL reg_wr_unexpected: got addr 0x%0h data 0x%0h, expected none", Reg_addr, Reg_wdata);
            end else begin
                e = exp_wr_q.pop_front();
                check("reg_wr_addr", 32'(Reg_addr), 32'(e.a));
                check("reg_wr_data", 32'(Reg_wdata), 32'(e.d));
            end
        end
        if (!Rst && Rd_strobe) begin
            if (exp_rd_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rd_strobe_unexpected: got addr 0x%0h, expected none", Reg_addr);
            end else begin
                ra = exp_rd_q.pop_front();
                check("rd_strobe_addr", 32'(Reg_addr), 32'(ra));
            end
        end
    end

    // SDA-hold watcher: Sda_oe may not move while synchronised SCL is high,
    // except a release caused by START/STOP or reset.
    logic oe_prev = 1'b0, abort_prev = 1'b0, rst_prev = 1'b1;
    always @(negedge Clk) begin
        if (!Rst && !rst_prev && (Sda_oe !== oe_prev) && dut.u_sync.scl_q[1]
            && !((Sda_oe == 1'b0) && abort_prev)) begin
            sda_viol++;
            $display("sda hold violation at %0t", $time);
        end
        oe_prev    <= Sda_oe;
        abort_prev <= dut.start_s | dut.stop_s;
        rst_prev   <= Rst;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model_mem[i] = 8'h10 + 8'(i);
        model_ptr = 0;
    endtask

    task automatic bus_start();
        wait_clk(Q); m_sda = 1'b1;
        wait_clk(Q); m_scl = 1'b1;
        wait_clk(Q); m_sda = 1'b0;
        wait_clk(Q); m_scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_stop();
        wait_clk(Q); m_sda = 1'b0;
        wait_clk(Q); m_scl = 1'b1;
        wait_clk(Q); m_sda = 1'b1;
        wait_clk(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;    wait_clk(Q);
        m_scl = 1'b1; wait_clk(2 * Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        b = Sda_i;    wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] v, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        write_bit(nack);
    endtask

    // Write transaction: pointer byte then the bytes queued in wr_bytes.
    task automatic do_write(input logic [7:0] ptr_byte);
        logic ack;
        model_ptr = int'(ptr_byte) % 8;
        foreach (wr_bytes[i]) begin
            wr_exp_t e;
            e.a = 3'(model_ptr);
            e.d = wr_bytes[i];
            exp_wr_q.push_back(e);
            model_mem[model_ptr] = wr_bytes[i];
            model_ptr = (model_ptr + 1) % 8;
        end
        bus_start();
        check("busy_after_start", 32'(Busy), 32'd1);
        write_byte(8'hA0, ack);
        check("wr_hdr_ack", 32'(ack), 32'd0);
        check("sel_after_hdr", 32'(Sel), 32'd1);
        write_byte(ptr_byte, ack);
        check("wr_ptr_ack", 32'(ack), 32'd0);
        foreach (wr_bytes[i]) begin
            write_byte(wr_bytes[i], ack);
            check("wr_data_ack", 32'(ack), 32'd0);
        end
        bus_stop();
        check("wr_end_ptr", 32'(Reg_addr), 32'(model_ptr));
        check("wr_busy_after_stop", 32'(Busy), 32'd0);
        check("wr_sel_after_stop", 32'(Sel), 32'd0);
    endtask

    // Read transaction of n bytes, optionally setting the pointer first and
    // reaching the read phase through a repeated START.
    task automatic do_read(input logic set_ptr, input logic [7:0] ptr_byte, input int n);
        logic       ack;
        logic [7:0] got;
        logic [7:0] exp_b [4];
        if (set_ptr) begin
            bus_start();
            write_byte(8'hA0, ack);
            check("rd_ptr_hdr_ack", 32'(ack), 32'd0);
            write_byte(ptr_byte, ack);
            check("rd_ptr_ack", 32'(ack), 32'd0);
            model_ptr = int'(ptr_byte) % 8;
        end
        for (int i = 0; i < n; i++) begin
            exp_b[i] = model_mem[model_ptr];
            exp_rd_q.push_back(3'(model_ptr));
            model_ptr = (model_ptr + 1) % 8;
        end
        bus_start();
        write_byte(8'hA1, ack);
        check("rd_hdr_ack", 32'(ack), 32'd0);
        for (int i = 0; i < n; i++) begin
            read_byte(got, (i == n - 1));
            check("rd_data", 32'(got), 32'(exp_b[i]));
        end
        check("rd_sda_released", 32'(Sda_oe), 32'd0);
        check("rd_sel_after_nack", 32'(Sel), 32'd0);
        bus_stop();
        check("rd_end_ptr", 32'(Reg_addr), 32'(model_ptr));
        check("rd_busy_after_stop", 32'(Busy), 32'd0);
    endtask

    task automatic do_mismatch(input logic [6:0] addr);
        logic ack;
        bus_start();
        write_byte({addr, 1'b0}, ack);
        check("mismatch_nack", 32'(ack), 32'd1);
        check("mismatch_sel", 32'(Sel), 32'd0);
        write_byte(8'h00, ack);
        check("mismatch_data_nack", 32'(ack), 32'd1);
        bus_stop();
        check("mismatch_busy", 32'(Busy), 32'd0);
        check("mismatch_ptr", 32'(Reg_addr), 32'(model_ptr));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sda_oe"}, 32'(Sda_oe), 32'd0);
        check({tag, "_reg_addr"}, 32'(Reg_addr), 32'd0);
        check({tag, "_reg_wdata"}, 32'(Reg_wdata), 32'd0);
        check({tag, "_reg_wr"}, 32'(Reg_wr), 32'd0);
        check({tag, "_busy"}, 32'(Busy), 32'd0);
        check({tag, "_sel"}, 32'(Sel), 32'd0);
        check({tag, "_rd_strobe"}, 32'(Rd_strobe), 32'd0);
    endtask

    initial begin
        logic       ack;
        logic [7:0] hdr;
        int         k;
        int         kind;
        int         nb;
        logic [6:0] bad;

        m_scl = 1'b1;
        m_sda = 1'b1;
        Rst   = 1'b1;
        model_reset();
        wait_clk(5);
        check_all_zero("reset");
        Rst = 1'b0;
        wait_clk(4);

        // Directed write: pointer 2, then 0x5A and 0xC3.
        wr_bytes = {8'h5A, 8'hC3};
        do_write(8'h02);

        // Address mismatch, then a good write.
        do_mismatch(7'h51);
        wr_bytes = {8'hA5};
        do_write(8'h01);

        // Read across the pointer wrap using a repeated START.
        do_read(1'b1, 8'h07, 2);

        // STOP inside a data byte after four bits.
        bus_start();
        write_byte(8'hA0, ack);
        check("abort_hdr_ack", 32'(ack), 32'd0);
        write_byte(8'h05, ack);
        check("abort_ptr_ack", 32'(ack), 32'd0);
        model_ptr = 5;
        for (int i = 0; i < 4; i++) write_bit(1'(i));
        bus_stop();
        check("abort_state_idle", 32'(dut.state_q), 32'(I2C_S_IDLE));
        check("abort_sda_oe", 32'(Sda_oe), 32'd0);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_ptr", 32'(Reg_addr), 32'd5);

        // Reset while the address ACK is being driven.
        bus_start();
        hdr = 8'hA0;
        for (int i = 7; i >= 0; i--) write_bit(hdr[i]);
        m_sda = 1'b1;
        k = 0;
        while (!Sda_oe && k < 40) begin
            wait_clk(1);
            k++;
        end
        check("ack_driven_before_rst", 32'(Sda_oe), 32'd1);
        Rst = 1'b1;
        wait_clk(1);
        check_all_zero("midrst");
        Rst = 1'b0;
        model_reset();
        read_bit(ack);
        check("midrst_no_ack", 32'(ack), 32'd1);
        write_byte(8'h03, ack);
        check("midrst_idle_no_ack", 32'(ack), 32'd1);
        bus_stop();
        wr_bytes = {8'h3C};
        do_write(8'h06);

        // Randomised traffic against the register-map model.
        for (int t = 0; t < 14; t++) begin
            kind = int'($urandom_range(0, 3));
            nb   = int'($urandom_range(1, 4));
            if (kind <= 1) begin
                wr_bytes.delete();
                for (int i = 0; i < nb; i++) wr_bytes.push_back(8'($urandom));
                do_write(8'($urandom));
            end else if (kind == 2) begin
                do_read(1'($urandom), 8'($urandom), nb);
            end else begin
                bad = 7'($urandom);
                if (bad == 7'h50) bad = 7'h2A;
                do_mismatch(bad);
            end
        end

        wait_clk(10);
        check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
        check("sda_hold_violations", 32'(sda_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
I2C target (slave) block that answers the bus transactions issued by the team's I2C master core. It decodes START, STOP and repeated START, and matches a 7-bit device address. It exposes an 8-bit register space through a simple synchronous local bus, with an auto-incrementing register pointer. It is used as a bus-functional responder in benches and as a peripheral front-end in the SoC.

Parameters:
SLV_ADDR, 7'h50, 7-bit I2C device address this block responds to
AWIDTH, 3, register-pointer width; the register space holds 2^AWIDTH bytes
DWIDTH, 8, data width; fixed at 8 by the protocol and not to be overridden

Ports:
Clk  input  1  system clock; must be at least 8x SCL
Rst  input  1  synchronous, active-high reset
Scl_i  input  1  SCL line level, asynchronous
Sda_i  input  1  SDA line level, asynchronous
Sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release
Reg_addr  output  AWIDTH  current register pointer
Reg_wdata  output  8  byte received from the master
Reg_wr  output  1  one-cycle write strobe for Reg_wdata at Reg_addr
Reg_rdata  input  8  read data at Reg_addr; combinational, valid in the same cycle
Busy  output  1  bus busy: set on START, cleared on STOP
Sel  output  1  high while this target is addressed (from address ACK until STOP/rSTART/NACK)
Rd_strobe  output  1  one-cycle pulse when a byte is loaded for transmission

Behaviour:
- Reset is synchronous, active-high, and one clock is used throughout. All outputs are 0 after reset, Reg_addr = 0, state IDLE.
- Scl_i and Sda_i each pass through a 2-flop synchroniser plus a history flop. The edge and condition detectors below run on the synchronised signals, giving a fixed 2-cycle input latency.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - SCL rise/fall: one-cycle pulses.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK, WAIT_STOP.
- START from any state (this covers repeated START): go to ADDR, clear the bit counter, drop Sel, release SDA.
- STOP from any state: go to IDLE, release SDA, drop Sel and Busy.
- ADDR: shift SDA in, MSB first, on each SCL rise; 8 bits make up the address plus the R/W bit.
  - On the SCL fall after bit 8: if addr == SLV_ADDR, set Sda_oe=1, set Sel=1, go to ADDR_ACK.
  - Otherwise go to WAIT_STOP with SDA released.
- ADDR_ACK: hold SDA low through the 9th SCL high. On the following SCL fall:
  - R/W=0 → WR_DATA, SDA released, first-byte flag set.
  - R/W=1 → RD_LOAD.
- WR_DATA: shift 8 bits in. On the SCL fall after bit 8, drive ACK and go to WR_ACK.
  - If the first-byte flag is set: Reg_addr ← byte[AWIDTH-1:0] and the flag clears. No Reg_wr is issued.
  - Otherwise: Reg_wdata ← byte and Reg_wr pulses for one cycle at the current Reg_addr.
  - Reg_addr increments in the cycle after the Reg_wr pulse.
- WR_ACK: release SDA on the next SCL fall and return to WR_DATA.
- RD_LOAD (lasts 1 cycle): capture Reg_rdata into the tx shift register, pulse Rd_strobe, and increment Reg_addr in the next cycle. Then drive bit 7 and go to RD_DATA.
- RD_DATA: SDA output changes only after SCL falls. Sda_oe = ~tx_bit.
  - After the 8th bit's SCL fall, release SDA and go to RD_ACK.
- RD_ACK: sample SDA on the SCL rise.
  - ACK (0) → RD_LOAD on the next SCL fall.
  - NACK (1) → WAIT_STOP, Sel=0.
- WAIT_STOP: SDA is released and the FSM ignores everything except START or STOP.
- Reg_addr wraps modulo 2^AWIDTH; from 7 it goes to 0 with AWIDTH=3.
- No clock stretching: SCL is never driven.
- SDA-hold guarantee: Sda_oe changes only in the cycle after a detected SCL fall, never while SCL is high. The only exception is STOP/START abort, which releases SDA.
- Reset mid-transfer: SDA is released immediately and the block re-arms only on the next START.

Decomposition:
- Add to the shared i2c defines include: the FSM state encodings (`I2C_S_*), the R/W bit position and the ACK/NACK constants.
- Sub-module i2c_slave_sync: synchroniser plus START/STOP/SCL-edge detector, reusable by the master core.

Test Plan:
- Write 0x5A then 0xC3 starting at pointer 2: START, 0xA0 (addr 0x50, W), 0x02, 0x5A, 0xC3, STOP.
  - ACK on all 4 bytes.
  - Reg_wr pulses twice: (addr 2, 0x5A) then (addr 3, 0xC3).
  - Reg_addr ends at 4; Busy falls after STOP.
- Address mismatch: START, 0xA2.
  - 9th bit is NACK (Sda_oe stays 0), Sel=0, no Reg_wr.
  - The following write to 0x50 after a STOP/START succeeds.
- Read with repeated START: write pointer 7, rSTART, 0xA1, master ACK, then master NACK, STOP. Bench model returns Reg_rdata = 8'h10 + Reg_addr.
  - Bytes received are 0x17 then 0x10 (wrap to 0).
  - Rd_strobe pulses twice; SDA released after the NACK.
- STOP inside a data byte after 4 bits:
  - FSM returns to IDLE, no Reg_wr, Sda_oe=0, Busy=0.
- Rst asserted while the block is driving the address ACK low:
  - Next cycle Sda_oe=0 and all outputs are 0.
  - No ACK/response until a fresh START + 0xA0.
- SDA timing check: in every transfer, a bench assertion flags any Sda_oe change while the synchronised SCL is high. The required error count is 0.
